// File: rtl/alu_pkg.sv
// Types shared by the 4-bit ALU and the scheduler that multiplexes requesters onto it.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD      = 4'd0,
    ADD_C    = 4'd1,
    SUB      = 4'd2,
    SUB_B    = 4'd3,
    AND_L    = 4'd4,
    OR_L     = 4'd5,
    XOR_L    = 4'd6,
    NOT_A    = 4'd7,
    INC      = 4'd8,
    DEC      = 4'd9,
    SHIFT_L  = 4'd10,
    SHIFT_R  = 4'd11,
    ROTATE_L = 4'd12,
    ROTATE_R = 4'd13
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  // Highest legal opcode; 14 and 15 are rejected with an error response.
  localparam opcode_e OPC_LAST = ROTATE_R;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, searching from the requester after the last grant.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         enable_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    if (enable_i) begin
      for (int unsigned i = 1; i <= N; i++) begin
        idx = PtrW'((32'(ptr_q) + i) % N);
        if (req_i[idx] && (grant_o == '0)) begin
          grant_o[idx] = 1'b1;
          ptr_d        = idx;
        end
      end
    end
  end

  // Pointer starts at N-1 so requester 0 wins first after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= PtrW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one registered 4-bit ALU between N_REQ requesters with per-requester carry flags.
module alu_sched
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [4*N_REQ-1:0] req_a,
  input  logic [4*N_REQ-1:0] req_b,
  input  logic [4*N_REQ-1:0] req_ctl,
  input  logic [N_REQ-1:0]   req_use_cf,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [3:0]         rsp_alu,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic               alu_valid_in,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic               alu_cin,
  output logic [3:0]         alu_ctl,
  input  logic               alu_valid_out,
  input  logic [3:0]         alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  sched_state_e     state_q;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] gnt_q;
  logic [PtrW-1:0]  gidx, gidx_q;
  logic [N_REQ-1:0] cf_q;
  logic [CntW-1:0]  cnt_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [3:0]       rsp_alu_q;
  logic             rsp_carry_q, rsp_zero_q, rsp_err_q;
  logic             alu_valid_in_q, alu_cin_q;
  logic [3:0]       alu_a_q, alu_b_q, alu_ctl_q;
  logic [3:0]       sel_a, sel_b, sel_ctl;
  logic             sel_cin, legal;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_valid),
    .enable_i (state_q == IDLE),
    .grant_o  (grant)
  );

  always_comb begin
    gidx    = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_ctl = '0;
    sel_cin = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gidx    = PtrW'(i);
        sel_a   = req_a[4*i +: 4];
        sel_b   = req_b[4*i +: 4];
        sel_ctl = req_ctl[4*i +: 4];
        sel_cin = req_use_cf[i] & cf_q[i];
      end
    end
    legal = (sel_ctl <= 4'(OPC_LAST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      gidx_q         <= '0;
      cf_q           <= '0;
      cnt_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_alu_q      <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
      alu_valid_in_q <= 1'b0;
      alu_cin_q      <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctl_q      <= '0;
    end else begin
      rsp_valid_q    <= '0;
      alu_valid_in_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|grant) begin
            gnt_q     <= grant;
            gidx_q    <= gidx;
            alu_a_q   <= sel_a;
            alu_b_q   <= sel_b;
            alu_ctl_q <= sel_ctl;
            alu_cin_q <= sel_cin;
            if (legal) begin
              alu_valid_in_q <= 1'b1;
              state_q        <= ISSUE;
            end else begin
              rsp_valid_q <= grant;
              rsp_alu_q   <= '0;
              rsp_carry_q <= 1'b0;
              rsp_zero_q  <= 1'b0;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (alu_valid_out) begin
            rsp_valid_q  <= gnt_q;
            rsp_alu_q    <= alu_result;
            rsp_carry_q  <= alu_carry;
            rsp_zero_q   <= alu_zero;
            rsp_err_q    <= 1'b0;
            cf_q[gidx_q] <= alu_carry;
            state_q      <= IDLE;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            rsp_valid_q <= gnt_q;
            rsp_alu_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant is combinational so the handshake completes in the same cycle as arbitration.
  assign req_ready    = grant;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_alu      = rsp_alu_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_err      = rsp_err_q;
  assign alu_valid_in = alu_valid_in_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_cin      = alu_cin_q;
  assign alu_ctl      = alu_ctl_q;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched with a small registered ALU model that can be muted.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int unsigned N = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [4*N-1:0] req_a = '0, req_b = '0, req_ctl = '0;
  logic [N-1:0]   req_use_cf = '0;
  logic [N-1:0]   rsp_valid;
  logic [3:0]     rsp_alu;
  logic           rsp_carry, rsp_zero, rsp_err;
  logic           alu_valid_in, alu_cin, alu_valid_out;
  logic [3:0]     alu_a, alu_b, alu_ctl;
  logic [3:0]     alu_r_m = '0;
  logic           alu_c_m = 1'b0, alu_vo_m = 1'b0;
  logic           alu_en = 1'b1, late_vo = 1'b0;
  logic [4:0]     sum;

  typedef struct {
    int       idx;
    logic [3:0] alu;
    logic     c, z, e;
    int       cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_sched #(
    .N_REQ   (N),
    .TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ctl       (req_ctl),
    .req_use_cf    (req_use_cf),
    .rsp_valid     (rsp_valid),
    .rsp_alu       (rsp_alu),
    .rsp_carry     (rsp_carry),
    .rsp_zero      (rsp_zero),
    .rsp_err       (rsp_err),
    .alu_valid_in  (alu_valid_in),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_cin       (alu_cin),
    .alu_ctl       (alu_ctl),
    .alu_valid_out (alu_valid_out),
    .alu_result    (alu_r_m),
    .alu_carry     (alu_c_m),
    .alu_zero      (alu_r_m == 4'd0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Only the add opcodes are exercised.
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    if (alu_ctl == 4'(ADD_C)) sum = sum + {4'd0, alu_cin};
  end

  always @(posedge clk) begin
    alu_vo_m <= alu_valid_in & alu_en;
    if (alu_valid_in) {alu_c_m, alu_r_m} <= sum;
  end
  assign alu_valid_out = alu_vo_m | late_vo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset && (|rsp_valid)) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
        check("rsp_alu", 32'(rsp_alu), 32'(e.alu));
        check("rsp_carry", 32'(rsp_carry), 32'(e.c));
        check("rsp_zero", 32'(rsp_zero), 32'(e.z));
        check("rsp_err", 32'(rsp_err), 32'(e.e));
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_op(input int r, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ctl, input logic ucf, input logic [3:0] ea,
                       input logic ec, input logic ez, input logic ee, input logic ecin,
                       input int lat, input logic issue);
    bit got = 0;
    @(posedge clk); #1;
    req_valid[r] = 1'b1;
    req_a[4*r +: 4] = a;
    req_b[4*r +: 4] = b;
    req_ctl[4*r +: 4] = ctl;
    req_use_cf[r] = ucf;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1;
    end
    check("req_ready", 32'(req_ready), 32'(1 << r));
    if (got) sb.push_back('{idx: r, alu: ea, c: ec, z: ez, e: ee, cyc: cyc + lat});
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    @(negedge clk);
    check("alu_valid_in", 32'(alu_valid_in), 32'(issue));
    if (issue) check("alu_cin", 32'(alu_cin), 32'(ecin));
    repeat (lat) @(negedge clk);
  endtask

  // Both requesters held valid; grants must alternate starting at 'first', 3 cycles apart.
  task automatic run_pair(input int ngrants, input int first, input logic [3:0] ea0,
                          input logic [3:0] ea1);
    int k = 0;
    int nxt = first;
    int lastc = 0;
    @(posedge clk); #1;
    req_valid = '1;
    for (int t = 0; t < 60 && k < ngrants; t++) begin
      @(negedge clk);
      if (|req_ready) begin
        check("rr_grant", 32'(req_ready), 32'(1 << nxt));
        if (k > 0) check("grant_gap", cyc - lastc, 3);
        sb.push_back('{idx: nxt, alu: (nxt == 0) ? ea0 : ea1, c: 1'b0, z: 1'b0, e: 1'b0,
                       cyc: cyc + 3});
        lastc = cyc;
        nxt = 1 - nxt;
        k++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    check("grant_count", k, ngrants);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_alu_valid_in", 32'(alu_valid_in), 0);
    check("rst_alu_ctl", 32'(alu_ctl), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    do_op(0, 4'd5, 4'd6, ADD, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    do_op(0, 4'd9, 4'd8, ADD, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    do_op(1, 4'd1, 4'd1, ADD, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    do_op(0, 4'd1, 4'd1, ADD_C, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    do_op(1, 4'd1, 4'd1, ADD_C, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    // cf1 set to 1, then an illegal op must leave it intact.
    do_op(1, 4'd15, 4'd1, ADD, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1);
    do_op(1, 4'd0, 4'd0, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    do_op(1, 4'd0, 4'd0, ADD_C, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1);

    req_a = {4'd2, 4'd1};
    req_b = {4'd2, 4'd2};
    req_ctl = {4'(ADD), 4'(ADD)};
    req_use_cf = '0;
    run_pair(4, 0, 4'd3, 4'd4);

    alu_en = 1'b0;
    do_op(0, 4'd1, 4'd1, ADD, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6, 1'b1);
    @(posedge clk); #1;
    late_vo = 1'b1;
    @(posedge clk); #1;
    late_vo = 1'b0;
    repeat (3) @(negedge clk);

    alu_en = 1'b1;
    do_op(0, 4'd9, 4'd8, ADD, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    alu_en = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_a[3:0] = 4'd1;
    req_b[3:0] = 4'd1;
    req_ctl[3:0] = 4'(ADD);
    @(negedge clk);
    check("pre_rst_grant", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_rst_rsp_alu", 32'(rsp_alu), 0);
    check("mid_rst_rsp_carry", 32'(rsp_carry), 0);
    check("mid_rst_alu_a", 32'(alu_a), 0);
    check("mid_rst_alu_b", 32'(alu_b), 0);
    check("mid_rst_alu_valid_in", 32'(alu_valid_in), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    alu_en = 1'b1;
    repeat (8) @(negedge clk);

    req_a = {4'd2, 4'd1};
    req_b = {4'd3, 4'd1};
    req_ctl = {4'(ADD), 4'(ADD_C)};
    req_use_cf = 2'b01;
    run_pair(2, 0, 4'd2, 4'd5);

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares the single 4-bit ALU between N_REQ requesters. It accepts one operation at a time through a valid/ready handshake and drives the ALU's input port. It then waits for the ALU's registered result and returns the result to the granted requester on a shared response bus. It also keeps one carry-flag register per requester so ADD_c/SUB_b chains from different requesters do not corrupt each other's carry.

## Interface
- N_REQ, 2: number of requesters (2..4).
- TIMEOUT, 4: cycles in WAIT without alu_valid_out before an error response.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  one-hot grant pulse; transfer when req_valid[i] & req_ready[i].
- req_a  in  4*N_REQ  operand A, requester i at [4i+3:4i].
- req_b  in  4*N_REQ  operand B, same packing.
- req_ctl  in  4*N_REQ  opcode (opcode_e encoding), same packing.
- req_use_cf  in  N_REQ  1 = drive ALU cin from requester's carry flag; 0 = cin 0.
- rsp_valid  out  N_REQ  one-hot, one-cycle response pulse.
- rsp_alu  out  4  result.
- rsp_carry  out  1  carry.
- rsp_zero  out  1  zero flag from the ALU, passed through unmodified.
- rsp_err  out  1  1 = illegal opcode or timeout; rsp_alu/carry/zero forced 0.
- alu_valid_in  out  1  to ALU valid_in.
- alu_a, alu_b  out  4  to ALU a, b.
- alu_cin  out  1  to ALU cin.
- alu_ctl  out  4  to ALU ctl.
- alu_valid_out  in  1  from ALU.
- alu_result  in  4  from ALU alu.
- alu_carry, alu_zero  in  1  from ALU.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid, the round-robin arbiter grants one requester. It searches from the requester after the last grant; after reset, requester 0 has priority.
  - The grant asserts req_ready[g] for one cycle.
  - On grant, latch a, b, ctl, and cin = req_use_cf[g] ? cf[g] : 0.
  - Legal ctl (0..13) → ISSUE.
  - Illegal ctl (14, 15) → stay IDLE; register an error response (rsp_valid[g]=1, rsp_err=1) in the next cycle.
  - The last-grant pointer advances on every grant, error grants included.
- ISSUE: drive alu_valid_in=1 with the latched operands for exactly one cycle → WAIT. Clear the timeout counter.
- WAIT:
  - If alu_valid_out=1, register the response: rsp_valid[g]=1, rsp_alu=alu_result, rsp_carry=alu_carry, rsp_zero=alu_zero, rsp_err=0.
  - In the same edge, set cf[g] <= alu_carry, then → IDLE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without valid, emit an error response, leave cf[g] unchanged, and → IDLE.
- alu_valid_in is 0 outside ISSUE. ALU-side outputs hold their latched values when idle.
- alu_valid_out outside WAIT is ignored. Typical cause: a late result after a timeout or reset.
- cf[i] is written only by a successful response to requester i.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_alu=0, rsp_carry=0, rsp_zero=0, rsp_err=0, alu_valid_in=0, alu_a=alu_b=alu_ctl=0, alu_cin=0. Also state=IDLE, all cf=0, last-grant pointer = N_REQ-1.
- Legal op, cycle by cycle:
  - cycle 0: grant (req_ready).
  - cycle 1: alu_valid_in.
  - cycle 2: ALU result valid; sampled at end of cycle 2.
  - cycle 3: rsp_valid. The FSM is in IDLE and may grant again in cycle 3.
  - Issue interval is 3 cycles per op; latency is 3 cycles from grant to response.
- Illegal op: grant in cycle 0, error response in cycle 1, next grant possible in cycle 1.
- Timeout: error response appears TIMEOUT cycles after entering WAIT, +1 registered cycle.
- Responses have no backpressure; the requester must sample rsp_valid.
- Requesters may drop req_valid without a grant; a request is committed only on the handshake.
- Reset mid-operation: the in-flight op is discarded with no response, and cf is cleared.

## Structure
- Shared package alu_pkg:
  - opcode_e, moved out of the ALU so both blocks import it.
  - sched_state_e {IDLE, ISSUE, WAIT}.
  - Constant OPC_LAST = ROTATE_R, the legal-opcode bound.
- One sub-module, rr_arbiter (parameter N):
  - Inputs: req vector, enable.
  - Output: one-hot grant.
  - Internal rotating last-grant pointer, updated on enable & |req.
- ALU stays a separate instance wired at the level above alu_sched.

## Test plan
- Single op: req0 ADD a=5 b=6, use_cf=0 → req_ready[0] cycle 0, alu_valid_in cycle 1, rsp_valid[0] cycle 3 with rsp_alu=11, rsp_carry=0, rsp_err=0.
- Per-requester carry isolation:
  - req0 ADD 9+8 → carry 1, cf0=1.
  - req1 ADD 1+1 → cf1=0.
  - req0 ADD_c 1+1 use_cf=1 → alu_cin=1, rsp_alu=3.
  - req1 ADD_c 1+1 use_cf=1 → alu_cin=0, rsp_alu=2.
- Fairness: req0 and req1 held valid continuously → grants alternate 0,1,0,1 every 3 cycles; both receive responses in grant order.
- Illegal opcode: req1 ctl=15 → req_ready[1] cycle 0; rsp_valid[1], rsp_err=1, rsp_alu=0 in cycle 1; alu_valid_in never asserted; cf1 unchanged.
- Timeout: stub ALU never asserts alu_valid_out, TIMEOUT=4 → error response 4 cycles after entering WAIT. A late alu_valid_out afterwards produces no response.
- Reset in WAIT: assert reset while req0's op is in WAIT → all outputs 0 immediately, no rsp_valid after release, cf0=0, and the first grant after release goes to requester 0.
